// File: rtl/slurm32_cpu_writeback_pipe.sv
// rtl/slurm32_cpu_writeback_pipe.sv - SLURM32 slot-4 writeback stage; optional forwarding outputs under SLURM32_WB_BYPASS_EN
module slurm32_cpu_writeback_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_SEL_W = 8,
    parameter int PC_W = 32,
    parameter logic [REG_SEL_W-1:0] IRQ_LR_SEL = REG_SEL_W'(8'h0F),
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           instruction,
    input  logic [DATA_W-1:0]     aluOut,
    input  logic [DATA_W-1:0]     memory_in,
    input  logic                  mem_valid,
    input  logic [DATA_W/8-1:0]   memory_mask_delayed,
    input  logic [PC_W-1:0]       pc_stage4,
    input  logic                  nop_stage4,
    input  logic                  load_interrupt_return_address,
    input  logic                  cond_pass,
    output logic                  stall_out,
    output logic                  reg_wr_en,
    output logic [REG_SEL_W-1:0]  reg_wr_sel,
    output logic [DATA_W-1:0]     reg_out,
    output logic                  mem_timeout
`ifdef SLURM32_WB_BYPASS_EN
    ,
    output logic                  fwd_valid,
    output logic [REG_SEL_W-1:0]  fwd_sel,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    localparam int NB = DATA_W / 8;
    localparam int EXT_W = (PC_W > DATA_W) ? PC_W : DATA_W;
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    // The entry cycle counts as the first stall cycle, so the last wait
    // cycle is reached when the counter equals MEM_TIMEOUT-1.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t               state;
    state_t               nxt_state;
    logic [CNT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]     nxt_cnt;
    logic [REG_SEL_W-1:0] lat_sel;
    logic [REG_SEL_W-1:0] nxt_lat_sel;
    logic [NB-1:0]        lat_mask;
    logic [NB-1:0]        nxt_lat_mask;

    logic                 nxt_wr_en;
    logic [REG_SEL_W-1:0] nxt_sel;
    logic [DATA_W-1:0]    nxt_out;
    logic                 nxt_timeout;

    logic [3:0]           cls;
    logic [REG_SEL_W-1:0] dest;
    logic                 is_alu;
    logic                 is_load;
    logic                 is_bl;
    logic                 cond_ok;
    logic                 qualify;
    logic [EXT_W-1:0]     link_ext;
    logic [EXT_W-1:0]     irq_ext;
    logic                 unused_bits;

    assign cls     = instruction[31:28];
    assign dest    = instruction[16+REG_SEL_W-1:16];
    assign is_alu  = (cls == 4'h2) || (cls == 4'h3);
    assign is_load = (cls == 4'h4);
    assign is_bl   = (cls == 4'h6);
    assign cond_ok = !instruction[27] || cond_pass;
    assign qualify = !nop_stage4 && (is_alu || is_load || is_bl) && cond_ok && (dest != '0);

    assign link_ext = EXT_W'(pc_stage4 + PC_W'(4));
    assign irq_ext  = EXT_W'(pc_stage4);
    assign unused_bits = ^{instruction, link_ext, irq_ext};

    // Right-justify the selected byte lanes; an empty mask means a full word.
    function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] data,
                                                     input logic [NB-1:0] mask);
        logic [DATA_W-1:0] shifted;
        int low;
        int pop;
        low = 0;
        pop = 0;
        for (int i = NB - 1; i >= 0; i--) begin
            if (mask[i]) low = i;
        end
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) pop++;
        end
        shifted = data >> (8 * low);
        for (int i = 0; i < NB; i++) begin
            if (i >= pop) shifted[8*i +: 8] = 8'h00;
        end
        if (mask == '0) shifted = data;
        return shifted;
    endfunction

    // Next-state, stall and next write-port values.
    always_comb begin
        nxt_state    = state;
        nxt_cnt      = wait_cnt;
        nxt_lat_sel  = lat_sel;
        nxt_lat_mask = lat_mask;
        nxt_wr_en    = 1'b0;
        nxt_sel      = '0;
        nxt_out      = aluOut;
        nxt_timeout  = 1'b0;
        stall_out    = 1'b0;
        case (state)
            IDLE: begin
                if (load_interrupt_return_address) begin
                    nxt_wr_en = 1'b1;
                    nxt_sel   = IRQ_LR_SEL;
                    nxt_out   = irq_ext[DATA_W-1:0];
                end else if (qualify) begin
                    if (is_alu) begin
                        nxt_wr_en = 1'b1;
                        nxt_sel   = dest;
                    end else if (is_bl) begin
                        nxt_wr_en = 1'b1;
                        nxt_sel   = dest;
                        nxt_out   = link_ext[DATA_W-1:0];
                    end else if (mem_valid) begin
                        nxt_wr_en = 1'b1;
                        nxt_sel   = dest;
                        nxt_out   = align_load(memory_in, memory_mask_delayed);
                    end else begin
                        stall_out    = 1'b1;
                        nxt_state    = WAIT_MEM;
                        nxt_cnt      = CNT_W'(1);
                        nxt_lat_sel  = dest;
                        nxt_lat_mask = memory_mask_delayed;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_valid) begin
                    nxt_wr_en = 1'b1;
                    nxt_sel   = lat_sel;
                    nxt_out   = align_load(memory_in, lat_mask);
                    nxt_state = IDLE;
                    nxt_cnt   = '0;
                end else begin
                    stall_out = 1'b1;
                    if (wait_cnt >= LAST_CNT) begin
                        nxt_timeout = 1'b1;
                        nxt_state   = IDLE;
                        nxt_cnt     = '0;
                    end else begin
                        nxt_cnt = wait_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_cnt   = '0;
            end
        endcase
    end

    // State, latched load context and registered write port.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            lat_sel     <= '0;
            lat_mask    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_sel  <= '0;
            reg_out     <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= nxt_state;
            wait_cnt    <= nxt_cnt;
            lat_sel     <= nxt_lat_sel;
            lat_mask    <= nxt_lat_mask;
            reg_wr_en   <= nxt_wr_en;
            reg_wr_sel  <= nxt_sel;
            reg_out     <= nxt_out;
            mem_timeout <= nxt_timeout;
        end
    end

`ifdef SLURM32_WB_BYPASS_EN
    assign fwd_valid = nxt_wr_en;
    assign fwd_sel   = nxt_sel;
    assign fwd_data  = nxt_out;
`endif

endmodule
